// File: rtl/nn_axil_pkg.sv
// Shared types and constants for the AXI4-Lite result reader.
package nn_axil_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AR   = 2'd1,
      R    = 2'd2,
      FIN  = 2'd3
   } rd_state_t;

   localparam logic [1:0] RESP_OKAY       = 2'b00;
   localparam int         DEF_NUM_CLASSES = 10;
   localparam int         DEF_DATA_W      = 32;

endpackage : nn_axil_pkg

// File: rtl/axi4_lite_result_reader.sv
// Reads NUM_CLASSES signed words over AXI4-Lite and reports the index and
// value of the largest one (lowest index wins on ties).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; outputs of the last run are held
// AR    | read address presented for the current word
// R     | waiting for read data of the current word
// FIN   | one-cycle done pulse with final class_idx/class_val/err
module axi4_lite_result_reader
   import nn_axil_pkg::*;
#(
   parameter int NUM_CLASSES = DEF_NUM_CLASSES,
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int TIMEOUT     = 256
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              start,
   output logic [ADDR_W-1:0] m_axil_araddr,
   output logic [2:0]        m_axil_arprot,
   output logic              m_axil_arvalid,
   input  logic              m_axil_arready,
   input  logic [DATA_W-1:0] m_axil_rdata,
   input  logic [1:0]        m_axil_rresp,
   input  logic              m_axil_rvalid,
   output logic              m_axil_rready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [3:0]        class_idx,
   output logic [DATA_W-1:0] class_val
);

   localparam int                TMO_W     = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_CLASSES - 1);

   rd_state_t          state;
   logic [ADDR_W-1:0]  word_cnt;
   // Down-counter of remaining wait cycles; terminal count 0 means timeout.
   logic [TMO_W-1:0]   tmo_cnt;

   logic ar_hs;
   logic r_hs;
   logic take_word;

   assign m_axil_arprot = 3'b000;
   assign m_axil_araddr = word_cnt;

   assign ar_hs     = m_axil_arvalid && m_axil_arready;
   assign r_hs      = m_axil_rvalid && m_axil_rready;
   // Word 0 seeds the running max; later words must be strictly greater.
   assign take_word = (word_cnt == '0) ||
                      ($signed(m_axil_rdata) > $signed(class_val));

   // Sequencer: address phase, data phase, max tracking and timeout.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state          <= IDLE;
         word_cnt       <= '0;
         tmo_cnt        <= '0;
         m_axil_arvalid <= 1'b0;
         m_axil_rready  <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         class_idx      <= '0;
         class_val      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state          <= AR;
                  word_cnt       <= '0;
                  tmo_cnt        <= TMO_LOAD;
                  m_axil_arvalid <= 1'b1;
                  busy           <= 1'b1;
                  err            <= 1'b0;
                  class_idx      <= '0;
                  class_val      <= '0;
               end
            end
            AR: begin
               if (ar_hs) begin
                  state          <= R;
                  tmo_cnt        <= TMO_LOAD;
                  m_axil_arvalid <= 1'b0;
                  m_axil_rready  <= 1'b1;
               end else if (tmo_cnt == '0) begin
                  state          <= FIN;
                  m_axil_arvalid <= 1'b0;
                  err            <= 1'b1;
                  done           <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end
            R: begin
               if (r_hs) begin
                  m_axil_rready <= 1'b0;
                  tmo_cnt       <= TMO_LOAD;
                  // Data carried by an error response never enters the max.
                  if (m_axil_rresp != RESP_OKAY) begin
                     state <= FIN;
                     err   <= 1'b1;
                     done  <= 1'b1;
                  end else begin
                     if (take_word) begin
                        class_val <= m_axil_rdata;
                        class_idx <= 4'(word_cnt);
                     end
                     if (word_cnt == LAST_WORD) begin
                        state <= FIN;
                        done  <= 1'b1;
                     end else begin
                        state          <= AR;
                        word_cnt       <= word_cnt + 1'b1;
                        m_axil_arvalid <= 1'b1;
                     end
                  end
               end else if (tmo_cnt == '0) begin
                  state         <= FIN;
                  m_axil_rready <= 1'b0;
                  err           <= 1'b1;
                  done          <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule : axi4_lite_result_reader

// File: tb/tb_axi4_lite_result_reader.sv
// Scoreboard bench for axi4_lite_result_reader with a configurable-latency
// AXI4-Lite slave model.
module tb_axi4_lite_result_reader;

   logic        aclk;
   logic        aresetn;
   logic        start;
   logic [3:0]  m_axil_araddr;
   logic [2:0]  m_axil_arprot;
   logic        m_axil_arvalid;
   logic        m_axil_arready;
   logic [31:0] m_axil_rdata;
   logic [1:0]  m_axil_rresp;
   logic        m_axil_rvalid;
   logic        m_axil_rready;
   logic        busy;
   logic        done;
   logic        err;
   logic [3:0]  class_idx;
   logic [31:0] class_val;

   axi4_lite_result_reader dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .start         (start),
      .m_axil_araddr (m_axil_araddr),
      .m_axil_arprot (m_axil_arprot),
      .m_axil_arvalid(m_axil_arvalid),
      .m_axil_arready(m_axil_arready),
      .m_axil_rdata  (m_axil_rdata),
      .m_axil_rresp  (m_axil_rresp),
      .m_axil_rvalid (m_axil_rvalid),
      .m_axil_rready (m_axil_rready),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .class_idx     (class_idx),
      .class_val     (class_val)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   // ---------------- slave model ----------------
   logic [31:0] mem [10];
   int  ar_lat = 1;     // cycles arvalid is high up to and including the handshake
   int  r_lat  = 1;     // cycles in the data phase up to and including the handshake
   bit  stall  = 1'b0;  // arready never asserted
   int  err_at = -1;    // word answered with SLVERR
   int  ar_cnt, r_cnt, r_addr;
   bit  r_pend;
   int  rd_cnt = 0;     // completed read data handshakes
   int  a5_cnt = 0;     // address handshakes to word 5

   assign m_axil_arready = !stall && m_axil_arvalid && (ar_cnt >= ar_lat - 1);
   assign m_axil_rvalid  = r_pend && (r_cnt >= r_lat - 1);
   assign m_axil_rdata   = mem[r_addr];
   assign m_axil_rresp   = (r_pend && r_addr == err_at) ? 2'b10 : 2'b00;

   always @(posedge aclk) begin
      if (!aresetn) begin
         ar_cnt <= 0;
         r_cnt  <= 0;
         r_addr <= 0;
         r_pend <= 1'b0;
      end else begin
         if (m_axil_arvalid && m_axil_arready) begin
            ar_cnt <= 0;
            r_pend <= 1'b1;
            r_cnt  <= 0;
            r_addr <= int'(m_axil_araddr);
            if (m_axil_araddr == 4'd5) a5_cnt <= a5_cnt + 1;
         end else if (m_axil_arvalid) begin
            ar_cnt <= ar_cnt + 1;
         end
         if (r_pend) begin
            if (m_axil_rvalid && m_axil_rready) begin
               r_pend <= 1'b0;
               rd_cnt <= rd_cnt + 1;
            end else begin
               r_cnt <= r_cnt + 1;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [3:0]  idx;
      logic [31:0] val;
      logic        err;
      int          lat;
      bit          chk_class;
      int          st;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   done_cnt = 0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // Monitor: pops an expectation on each done and checks protocol holds.
   initial begin : monitor
      exp_t        e;
      bit          chk_after = 1'b0;
      logic        last_err  = 1'b0;
      bit          prev_stall = 1'b0;
      logic [3:0]  prev_addr = '0;
      forever begin
         @(negedge aclk);
         if (chk_after) begin
            chk_after = 1'b0;
            check("done_one_cycle", {63'b0, done}, 64'd0);
            check("err_held", {63'b0, err}, {63'b0, last_err});
         end
         if (aresetn && prev_stall && !done) begin
            check("ar_stable", {59'b0, m_axil_arvalid, m_axil_araddr},
                  {59'b0, 1'b1, prev_addr});
         end
         prev_stall = aresetn && m_axil_arvalid && !m_axil_arready;
         prev_addr  = m_axil_araddr;
         if (aresetn && done) begin
            done_cnt++;
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
               e = q.pop_front();
               check("err", {63'b0, err}, {63'b0, e.err});
               check("latency", 64'(cyc - e.st), 64'(e.lat));
               check("busy_at_done", {63'b0, busy}, 64'd1);
               if (e.chk_class) begin
                  check("class_idx", {60'b0, class_idx}, {60'b0, e.idx});
                  check("class_val", {32'b0, class_val}, {32'b0, e.val});
               end
               chk_after = 1'b1;
               last_err  = e.err;
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic load_default();
      mem[0] = 32'h0000abcd; mem[1] = 32'h1111babe; mem[2] = 32'h2222cafe;
      mem[3] = 32'h3333dead; mem[4] = 32'h4444efed; mem[5] = 32'h5555fade;
      mem[6] = 32'h6666abcd; mem[7] = 32'h7777babe; mem[8] = 32'h8888cafe;
      mem[9] = 32'h9999dead;
   endtask

   task automatic fill(input logic [31:0] v);
      for (int i = 0; i < 10; i++) mem[i] = v;
   endtask

   task automatic do_run(input int arl, input int rl, input bit stl, input int erw,
                         input logic [3:0] ei, input logic [31:0] ev, input logic ee,
                         input int el, input bit cc, input bit dbl);
      exp_t e;
      int   base;
      ar_lat = arl;
      r_lat  = rl;
      stall  = stl;
      err_at = erw;
      @(negedge aclk);
      base = done_cnt;
      e.idx = ei; e.val = ev; e.err = ee; e.lat = el; e.chk_class = cc; e.st = cyc;
      q.push_back(e);
      start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      if (dbl) begin
         repeat (4) @(negedge aclk);
         start = 1'b1;
         @(negedge aclk);
         start = 1'b0;
      end
      for (int k = 0; k < 1000 && done_cnt == base; k++) @(negedge aclk);
      if (done_cnt == base) begin
         total++;
         bad++;
         $display("FAIL done_timeout no done within 1000 cycles");
         q.delete();
      end
      repeat (3) @(negedge aclk);
   endtask

   task automatic chk_rst(input string nm);
      check(nm, {30'b0, m_axil_arvalid, m_axil_rready, busy, done, err,
                 m_axil_araddr, class_idx, class_val}, 64'd0);
   endtask

   initial begin : driver
      int rd0, a50;
      bit found;
      aresetn = 1'b0;
      start   = 1'b0;
      load_default();
      repeat (3) @(negedge aclk);
      chk_rst("reset_outputs");
      check("arprot", {61'b0, m_axil_arprot}, 64'd0);
      @(posedge aclk); #1 aresetn = 1'b1;
      @(negedge aclk);
      check("arvalid_after_reset", {62'b0, m_axil_arvalid, busy}, 64'd0);

      // Default words, zero wait: signed max is word 7.
      do_run(1, 1, 0, -1, 4'd7, 32'h7777babe, 1'b0, 21, 1, 0);
      // Tie between words 3 and 8, everything else -1.
      fill(32'hFFFFFFFF); mem[3] = 32'h00001000; mem[8] = 32'h00001000;
      do_run(1, 1, 0, -1, 4'd3, 32'h00001000, 1'b0, 21, 1, 0);
      // All equal negative: word 0 is kept.
      fill(32'h80000000);
      do_run(1, 1, 0, -1, 4'd0, 32'h80000000, 1'b0, 21, 1, 0);
      // Largest value in the last word.
      mem[9] = 32'h7FFFFFFF;
      do_run(1, 1, 0, -1, 4'd9, 32'h7FFFFFFF, 1'b0, 21, 1, 0);
      // Slow slave, plus a stray start mid-run that must be ignored.
      load_default();
      do_run(3, 3, 0, -1, 4'd7, 32'h7777babe, 1'b0, 61, 1, 1);
      // SLVERR on word 4.
      rd0 = rd_cnt; a50 = a5_cnt;
      do_run(1, 1, 0, 4, 4'd0, 32'h0, 1'b1, 11, 0, 0);
      check("err_read_count", 64'(rd_cnt - rd0), 64'd5);
      check("err_no_addr5", 64'(a5_cnt - a50), 64'd0);
      // arready stuck low: timeout, class outputs cleared by the start.
      do_run(1, 1, 1, -1, 4'd0, 32'h0, 1'b1, 257, 1, 0);

      // Reset during word 6, then a clean run.
      ar_lat = 1; r_lat = 1; stall = 1'b0; err_at = -1;
      @(negedge aclk);
      start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         if (m_axil_arvalid && m_axil_araddr == 4'd6) found = 1'b1;
         else @(negedge aclk);
      end
      check("reached_word6", {63'b0, found}, 64'd1);
      @(posedge aclk); #1 aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      chk_rst("midrun_reset_outputs");
      @(posedge aclk); #1 aresetn = 1'b1;
      @(negedge aclk);
      check("arvalid_after_midrun_reset", {62'b0, m_axil_arvalid, busy}, 64'd0);
      repeat (30) @(negedge aclk);
      do_run(1, 1, 0, -1, 4'd7, 32'h7777babe, 1'b0, 21, 1, 0);

      check("queue_empty", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog simulation did not finish, total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

endmodule : tb_axi4_lite_result_reader
